// File: rtl/mpmc11_pkg.sv
// -----------------------------------------------------------------------------
// mpmc11_pkg
// Types and helpers shared by the read-data collector and the request
// address path of the mpmc11 memory controller.
//
// Contents
//   mpmc11_rdc_state_t  state encoding of the read-data collector FSM
//   BEAT_ALIGN_MASK     clears the byte offset inside a 32-byte beat
//   ADDR_SPACE_MASK     30-bit controller address space; upper two bits zero
//   beat_addr()         address of beat number idx of a burst starting at base
// -----------------------------------------------------------------------------
package mpmc11_pkg;

    typedef enum logic [1:0] {
        RDC_IDLE    = 2'd0,
        RDC_COLLECT = 2'd1,
        RDC_DRAIN   = 2'd2
    } mpmc11_rdc_state_t;

    localparam logic [31:0] BEAT_ALIGN_MASK = 32'hFFFF_FFE0;
    localparam logic [31:0] ADDR_SPACE_MASK = 32'h3FFF_FFFF;

    // Beat address inside a burst. The sum wraps inside the 30-bit address
    // space, exactly as the request side computes app_addr, so both ends of
    // the read path agree on the address tagged to every beat.
    function automatic logic [31:0] beat_addr(
        input logic [31:0] base,
        input logic [8:0]  idx,
        input int          wid
    );
        logic [31:0] step;
        step = 32'(wid / 8);
        return (base + 32'(idx) * step) & ADDR_SPACE_MASK;
    endfunction

endpackage

// File: rtl/mpmc11_rdc_fifo.sv
// -----------------------------------------------------------------------------
// mpmc11_rdc_fifo
// Synchronous first-word-fall-through beat buffer for the read-data collector.
// A word written in cycle N is visible on rd_data (with empty low) in N+1.
// A write into a full buffer is accepted when a read happens in the same cycle.
//
// Parameters
//   WID    data width in bits
//   DEPTH  number of entries, power of two, >= 2
//
// Ports
//   clk      in   clock
//   rst      in   synchronous reset, active-high (pointers and level only)
//   wr       in   write request
//   wr_data  in   WID  data to write
//   rd       in   read request (pop the head word)
//   rd_data  out  WID  head word, zero while empty
//   full     out  buffer holds DEPTH words
//   empty    out  buffer holds no words
//   count    out  number of words held
// -----------------------------------------------------------------------------
module mpmc11_rdc_fifo #(
    parameter int WID   = 256,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WID-1:0]           wr_data,
    input  logic                     rd,
    output logic [WID-1:0]           rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WID-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    level;
    logic           do_wr;
    logic           do_rd;

    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);
    assign count = level;

    assign do_rd = rd & ~empty;
    // A full buffer still takes a word when the head leaves in the same cycle.
    assign do_wr = wr & (~full | do_rd);

    // Stale words stay in storage after a pop; zero the head while empty so
    // the channel never sees leftover data.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left without reset; the level
    // counter and read-data gating make its contents irrelevant until written.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mpmc11_rd_data_collect.sv
// -----------------------------------------------------------------------------
// mpmc11_rd_data_collect
// Receive end of the read path. Gathers the beats returned by the memory UI
// for one burst, counts them against the burst length, tags each beat with
// its 32-byte-aligned address and streams them to the channel port over a
// valid/ready interface.
//
// Parameters
//   WID         beat width in bits (WID/8 bytes of address per beat)
//   FIFO_DEPTH  beat buffer entries, power of two, >= 2
//
// Ports
//   clk                in   clock
//   rst                in   synchronous reset, active-high
//   start              in   pulse: read burst issued
//   burst_len          in   8    beats minus one, sampled on start
//   addr_base          in   32   burst start address, sampled on start
//   app_rd_data_valid  in   memory UI beat valid (no back-pressure possible)
//   app_rd_data        in   WID  memory UI beat data
//   out_valid          out  beat available to the channel
//   out_ready          in   channel accepts the beat
//   out_data           out  WID  beat data
//   out_addr           out  32   beat address
//   out_last           out  beat is the final one of the burst
//   busy               out  burst in progress
//   done               out  one-cycle pulse: final beat handed off
//   err_ovf            out  sticky: a beat arrived with the buffer full and
//                           was dropped; cleared by the next start
// -----------------------------------------------------------------------------
module mpmc11_rd_data_collect
    import mpmc11_pkg::*;
#(
    parameter int WID        = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       burst_len,
    input  logic [31:0]      addr_base,
    input  logic             app_rd_data_valid,
    input  logic [WID-1:0]   app_rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WID-1:0]   out_data,
    output logic [31:0]      out_addr,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err_ovf
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mpmc11_rdc_state_t state;
    mpmc11_rdc_state_t state_next;

    logic [7:0]    len;
    logic [31:0]   base;
    // One bit wider than burst_len so a 256-beat burst (len = 255) can
    // reach its terminal count of len + 1.
    logic [8:0]    rx_cnt;
    logic [7:0]    tx_cnt;

    logic          collecting;
    logic          rx_done;
    logic          take_start;
    logic          capture;
    logic          pop;
    logic          fifo_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    assign rx_done    = (rx_cnt == ({1'b0, len} + 9'd1));
    assign take_start = start & (state == RDC_IDLE);
    // Beats outside COLLECT, or beyond the burst length, are not counted.
    assign capture    = collecting & app_rd_data_valid & ~rx_done;
    assign pop        = out_valid & out_ready;
    assign fifo_wr    = capture & (~fifo_full | pop);

    mpmc11_rdc_fifo #(
        .WID   (WID),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (fifo_wr),
        .wr_data (app_rd_data),
        .rd      (pop),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = ~fifo_empty;

    // tx_cnt == len marks the last beat of a clean burst. After an overflow
    // fewer beats exist than the burst length, so the final stored beat is
    // recognised instead as the only buffered word once reception is over;
    // this keeps out_last and done working for truncated bursts.
    assign out_last = out_valid &
                      ((tx_cnt == len) | (rx_done & (fifo_count == CW'(1))));
    assign done     = pop & out_last;

    // Address is zero whenever no beat is presented.
    assign out_addr = out_valid ? beat_addr(base, {1'b0, tx_cnt}, WID) : 32'h0;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= RDC_IDLE;
        else     state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives state_next
        // and no latch is inferred.
        state_next = state;
        unique case (state)
            RDC_IDLE: begin
                if (start) state_next = RDC_COLLECT;
            end
            RDC_COLLECT: begin
                // The final beat can be captured and handed off back-to-back
                // before DRAIN is ever entered.
                if (done)         state_next = RDC_IDLE;
                else if (rx_done) state_next = RDC_DRAIN;
            end
            RDC_DRAIN: begin
                if (done) state_next = RDC_IDLE;
            end
            default: state_next = RDC_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy       = (state != RDC_IDLE);
        collecting = (state == RDC_COLLECT);
    end

    // ------------------------------------------------------------------
    // Burst registers, beat counters and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            len     <= '0;
            base    <= '0;
            rx_cnt  <= '0;
            tx_cnt  <= '0;
            err_ovf <= 1'b0;
        end else if (take_start) begin
            len     <= burst_len;
            base    <= addr_base & BEAT_ALIGN_MASK;
            rx_cnt  <= '0;
            tx_cnt  <= '0;
            err_ovf <= 1'b0;
        end else begin
            // A dropped beat still counts, so the burst always terminates.
            if (capture)            rx_cnt  <= rx_cnt + 9'd1;
            if (capture & ~fifo_wr) err_ovf <= 1'b1;
            if (pop)                tx_cnt  <= tx_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mpmc11_rd_data_collect.sv
// -----------------------------------------------------------------------------
// tb_mpmc11_rd_data_collect
// Bench for the read-data collector. A behavioural model (a queue of stored
// beats plus burst bookkeeping) predicts every output each cycle; a vector
// table covers two fixed bursts, hand sequences cover overflow, stalls,
// reset mid-burst and full-buffer write-through, and random bursts follow.
// -----------------------------------------------------------------------------
module tb_mpmc11_rd_data_collect;

    localparam int WID   = 256;
    localparam int DEPTH = 8;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       burst_len;
    logic [31:0]      addr_base;
    logic             app_rd_data_valid;
    logic [WID-1:0]   app_rd_data;
    logic             out_valid;
    logic             out_ready;
    logic [WID-1:0]   out_data;
    logic [31:0]      out_addr;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             err_ovf;

    always #5 clk = ~clk;

    mpmc11_rd_data_collect #(
        .WID        (WID),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .burst_len         (burst_len),
        .addr_base         (addr_base),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data       (app_rd_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_addr          (out_addr),
        .out_last          (out_last),
        .busy              (busy),
        .done              (done),
        .err_ovf           (err_ovf)
    );

    int total = 0;
    int bad   = 0;
    int n_pop = 0;
    int n_done = 0;

    // ---------------------------------------------------------------- checks
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {255'b0, act}, {255'b0, exp});
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, {224'b0, act}, {224'b0, exp});
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        check(name, {224'b0, 32'(act)}, {224'b0, 32'(exp)});
    endtask

    task automatic check_idle_outputs(input string tag);
        check1({tag, " out_valid"}, out_valid, L);
        check ({tag, " out_data"},  out_data,  '0);
        check32({tag, " out_addr"}, out_addr,  32'h0);
        check1({tag, " out_last"},  out_last,  L);
        check1({tag, " busy"},      busy,      L);
        check1({tag, " done"},      done,      L);
        check1({tag, " err_ovf"},   err_ovf,   L);
    endtask

    // ------------------------------------------------------ reference model
    // Beats the channel has yet to receive, in arrival order, plus the
    // bookkeeping of the current burst.
    logic [WID-1:0] m_q[$];
    bit             m_busy = 1'b0;
    int             m_len  = 0;
    int             m_rx   = 0;
    int             m_tx   = 0;
    bit [31:0]      m_base = '0;
    bit             m_err  = 1'b0;

    task automatic model_check();
        bit        ev;
        bit        el;
        bit [31:0] ea;
        ev = (m_q.size() > 0);
        // The last beat is the only one left once every beat has arrived.
        el = ev && (m_rx == m_len + 1) && (m_q.size() == 1);
        ea = (m_base + 32'(m_tx) * 32'd32) & 32'h3FFF_FFFF;
        check1("out_valid", out_valid, ev);
        check1("out_last",  out_last,  el);
        check1("done",      done,      el && out_ready);
        check1("busy",      busy,      m_busy);
        check1("err_ovf",   err_ovf,   m_err);
        if (ev) begin
            check("out_data", out_data, m_q[0]);
            check32("out_addr", out_addr, ea);
        end
        if (out_valid && out_ready) n_pop++;
        if (done) n_done++;
    endtask

    task automatic model_step();
        int sz;
        bit pop;
        bit last;
        bit was_busy;
        if (rst) begin
            m_q.delete();
            m_busy = 1'b0; m_len = 0; m_rx = 0; m_tx = 0; m_base = '0; m_err = 1'b0;
            return;
        end
        sz       = m_q.size();
        pop      = (sz > 0) && out_ready;
        last     = (sz == 1) && (m_rx == m_len + 1);
        was_busy = m_busy;
        if (pop) begin
            void'(m_q.pop_front());
            m_tx++;
        end
        if (was_busy && app_rd_data_valid && (m_rx < m_len + 1)) begin
            if ((sz < DEPTH) || pop) m_q.push_back(app_rd_data);
            else m_err = 1'b1;
            m_rx++;
        end
        if (pop && last) m_busy = 1'b0;
        if (start && !was_busy) begin
            m_busy = 1'b1;
            m_len  = int'(burst_len);
            m_base = addr_base & 32'hFFFF_FFE0;
            m_rx   = 0;
            m_tx   = 0;
            m_err  = 1'b0;
        end
    endtask

    // ------------------------------------------------------- cycle helpers
    // Inputs are driven 1 time unit after the rising edge; outputs are
    // sampled on the falling edge.
    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic drive(input logic s, input logic [7:0] l, input logic [31:0] b,
                         input logic v, input logic [WID-1:0] d, input logic r);
        start = s; burst_len = l; addr_base = b;
        app_rd_data_valid = v; app_rd_data = d; out_ready = r;
    endtask

    function automatic logic [WID-1:0] pat(input logic [31:0] x);
        return {8{x}};
    endfunction

    function automatic logic [WID-1:0] rand_beat();
        logic [WID-1:0] r;
        for (int k = 0; k < WID / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Run with idle inputs until the model says the burst is over.
    task automatic drain_until_idle(input string tag);
        int guard;
        guard = 0;
        while (m_busy && guard < 200) begin
            drive(L, 8'd0, 32'h0, L, '0, H);
            cycle();
            guard++;
        end
        check1({tag, " busy at end"}, busy, L);
    endtask

    // --------------------------------------------------------- vector table
    typedef struct {
        logic        start;
        logic [7:0]  len;
        logic [31:0] base;
        logic        valid;
        logic [31:0] data;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic [31:0] e_addr;
        logic        e_last;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    function automatic vec_t v(logic s, logic [7:0] l, logic [31:0] b, logic vl,
                               logic [31:0] d, logic r, logic ev, logic [31:0] ed,
                               logic [31:0] ea, logic el, logic edn, logic eb);
        vec_t x;
        x.start = s; x.len = l; x.base = b; x.valid = vl; x.data = d; x.ready = r;
        x.e_valid = ev; x.e_data = ed; x.e_addr = ea; x.e_last = el; x.e_done = edn; x.e_busy = eb;
        return x;
    endfunction

    vec_t vecs[$];

    // ----------------------------------------------------------------- test
    initial begin
        // Burst of 4 from an unaligned base; one cycle of latency, last on 4th.
        vecs.push_back(v(H, 8'd3, 32'h0000_1234, L, 32'h0,    H, L, 32'h0,    32'h0,         L, L, L));
        vecs.push_back(v(L, 8'd0, 32'h0,         H, 32'hD00, H, L, 32'h0,    32'h0,         L, L, H));
        vecs.push_back(v(L, 8'd0, 32'h0,         H, 32'hD01, H, H, 32'hD00, 32'h0000_1220, L, L, H));
        vecs.push_back(v(L, 8'd0, 32'h0,         H, 32'hD02, H, H, 32'hD01, 32'h0000_1240, L, L, H));
        vecs.push_back(v(L, 8'd0, 32'h0,         H, 32'hD03, H, H, 32'hD02, 32'h0000_1260, L, L, H));
        vecs.push_back(v(L, 8'd0, 32'h0,         L, 32'h0,    H, H, 32'hD03, 32'h0000_1280, H, H, H));
        vecs.push_back(v(L, 8'd0, 32'h0,         L, 32'h0,    H, L, 32'h0,    32'h0,         L, L, L));
        // Two-beat burst at the top of the 30-bit space wraps to zero.
        vecs.push_back(v(H, 8'd1, 32'h3FFF_FFE0, L, 32'h0,    H, L, 32'h0,    32'h0,         L, L, L));
        vecs.push_back(v(L, 8'd0, 32'h0,         H, 32'hE00, H, L, 32'h0,    32'h0,         L, L, H));
        vecs.push_back(v(L, 8'd0, 32'h0,         H, 32'hE01, H, H, 32'hE00, 32'h3FFF_FFE0, L, L, H));
        vecs.push_back(v(L, 8'd0, 32'h0,         L, 32'h0,    H, H, 32'hE01, 32'h0000_0000, H, H, H));
        vecs.push_back(v(L, 8'd0, 32'h0,         L, 32'h0,    H, L, 32'h0,    32'h0,         L, L, L));

        rst = H;
        drive(L, 8'd0, 32'h0, L, '0, H);
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = L;

        // --- table-driven bursts
        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].len, vecs[i].base, vecs[i].valid,
                  pat(vecs[i].data), vecs[i].ready);
            sample();
            check1($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_valid);
            check1($sformatf("vec%0d out_last", i),  out_last,  vecs[i].e_last);
            check1($sformatf("vec%0d done", i),      done,      vecs[i].e_done);
            check1($sformatf("vec%0d busy", i),      busy,      vecs[i].e_busy);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d out_data", i),   out_data, pat(vecs[i].e_data));
                check32($sformatf("vec%0d out_addr", i), out_addr, vecs[i].e_addr);
            end
            advance();
        end

        // --- 16 beats into 8 entries with the channel stalled until cycle 20
        n_pop = 0; n_done = 0;
        drive(H, 8'd15, 32'h0000_8000, L, '0, L);
        cycle();
        for (int i = 1; i < 20; i++) begin
            drive(L, 8'd0, 32'h0, (i <= 16), pat(32'hB000_0000 + i), L);
            cycle();
        end
        check1("ovf err_ovf before drain", err_ovf, H);
        drain_until_idle("ovf");
        check_int("ovf beats drained", n_pop, 8);
        check_int("ovf done pulses", n_done, 1);
        check1("ovf err_ovf sticky", err_ovf, H);

        // --- 8 beats with out_ready toggling every cycle
        n_pop = 0; n_done = 0;
        drive(H, 8'd7, 32'h0001_0047, L, '0, H);
        cycle();
        begin
            int sent;
            int guard;
            sent = 0; guard = 0;
            while (m_busy && guard < 100) begin
                drive(L, 8'd0, 32'h0, (sent < 8), pat(32'hC000_0000 + sent), (guard % 2 == 0));
                if (sent < 8) sent++;
                cycle();
                guard++;
            end
        end
        check1("toggle busy at end", busy, L);
        check_int("toggle beats drained", n_pop, 8);
        check1("toggle err_ovf", err_ovf, L);

        // --- start while busy, then reset after 2 of 4 beats
        n_done = 0;
        drive(H, 8'd3, 32'h0002_0000, L, '0, L);
        cycle();
        drive(L, 8'd0, 32'h0, H, pat(32'hD000_0000), L);
        cycle();
        drive(H, 8'd0, 32'h0005_0000, H, pat(32'hD000_0001), L);
        cycle();
        check1("rst-seq busy after ignored start", busy, H);
        rst = H;
        drive(L, 8'd0, 32'h0, H, pat(32'hD000_0002), L);
        cycle();
        rst = L;
        check_idle_outputs("after mid-burst rst");
        drive(L, 8'd0, 32'h0, H, pat(32'hD000_0003), H);
        cycle();
        drive(L, 8'd0, 32'h0, L, '0, H);
        cycle();
        check1("rst-seq stray beat ignored", out_valid, L);
        drive(H, 8'd0, 32'h0006_0010, L, '0, H);
        cycle();
        drive(L, 8'd0, 32'h0, H, pat(32'hD000_0004), H);
        cycle();
        drain_until_idle("rst-seq");
        check_int("rst-seq done pulses", n_done, 1);

        // --- full buffer with a pop and a new beat in the same cycle
        n_pop = 0;
        drive(H, 8'd9, 32'h0000_0400, L, '0, L);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(L, 8'd0, 32'h0, H, pat(32'hE000_0000 + i), L);
            cycle();
        end
        check1("full head valid", out_valid, H);
        drive(L, 8'd0, 32'h0, H, pat(32'hE000_0008), H);
        cycle();
        check1("full write-through err_ovf", err_ovf, L);
        drive(L, 8'd0, 32'h0, H, pat(32'hE000_0009), H);
        cycle();
        drain_until_idle("full");
        check_int("full beats drained", n_pop, 10);
        check1("full err_ovf at end", err_ovf, L);

        // --- random bursts against the model
        for (int b = 0; b < 25; b++) begin
            int guard;
            drive(H, 8'($urandom_range(0, 20)), $urandom, ($urandom_range(0, 1) == 1), rand_beat(), H);
            cycle();
            guard = 0;
            while (m_busy && guard < 400) begin
                drive(($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)), $urandom,
                      ($urandom_range(0, 9) < 7), rand_beat(), ($urandom_range(0, 9) < 6));
                cycle();
                guard++;
            end
            check1($sformatf("rand burst %0d ends", b), busy, L);
            drive(L, 8'd0, 32'h0, ($urandom_range(0, 1) == 1), rand_beat(), H);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
